// File: rtl/vga_sync_decoder.sv
// Sync decoder: locks to raw VGA HSYNC/VSYNC and rebuilds pixel position, visible flag and frame strobe.
// Optional per-frame CRC of visible pixels when VGA_DECODER_CRC_EN is defined.
module vga_sync_decoder #(
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned H_START     = 144,
  parameter int unsigned V_START     = 35,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic [2:0]  i_red_video,
  input  logic [2:0]  i_grn_video,
  input  logic [2:0]  i_blu_video,
  output logic [9:0]  o_hpos,
  output logic [9:0]  o_vpos,
  output logic        o_visible,
  output logic        o_frame_strobe,
  output logic        o_locked,
  output logic [2:0]  o_red_video,
  output logic [2:0]  o_grn_video,
  output logic [2:0]  o_blu_video,
  output logic [15:0] o_frame_crc
);

  localparam int unsigned HW  = 11;
  localparam int unsigned VW  = 10;
  localparam int unsigned PW  = 10;
  localparam int unsigned CW  = 3;
  localparam int unsigned GW  = 3;
  localparam int unsigned CRW = 16;
  localparam logic [HW-1:0] H_MAX = '1;
  localparam logic [VW-1:0] V_MAX = '1;

  typedef enum logic [1:0] {ST_SEARCH, ST_VERIFY, ST_LOCKED} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   good_cnt_q, good_cnt_d;
  logic            hs_prev_q, vs_prev_q;
  logic [HW-1:0]   h_cnt_q, h_cnt_d;
  logic [VW-1:0]   v_cnt_q, v_cnt_d;
  logic            v_arm_q, v_arm_d;
  logic            he, ve, frame_he, h_sat, line_bad, frame_bad;

  logic [PW-1:0]   hpos_q, hpos_d, vpos_q, vpos_d;
  logic            vis_q, vis_d, strobe_q, strobe_d, locked_q, locked_d;
  logic [CW-1:0]   red_q, red_d, grn_q, grn_d, blu_q, blu_d;
  logic            h_win, v_win;

  // Edge detection, position counters and line/frame length checks for the current sample
  always_comb begin
    he       = hs_prev_q & ~i_hsync;
    ve       = vs_prev_q & ~i_vsync;
    frame_he = he & (v_arm_q | ve);
    h_cnt_d  = h_cnt_q;
    v_cnt_d  = v_cnt_q;
    v_arm_d  = v_arm_q;
    if (he) begin
      h_cnt_d = '0;
    end else if (h_cnt_q != H_MAX) begin
      h_cnt_d = h_cnt_q + HW'(1);
    end
    if (frame_he) begin
      v_cnt_d = '0;
      v_arm_d = 1'b0;
    end else begin
      if (he && (v_cnt_q != V_MAX)) v_cnt_d = v_cnt_q + VW'(1);
      if (ve) v_arm_d = 1'b1;
    end
    h_sat     = ~he & (h_cnt_d == H_MAX);
    line_bad  = h_sat | (he & ((12'(h_cnt_q) + 12'd1) != 12'(H_TOTAL)));
    frame_bad = frame_he & ((11'(v_cnt_q) + 11'd1) != 11'(V_TOTAL));
  end

  // Lock FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_SEARCH;
      good_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
    end
  end

  // Lock FSM: next state; a bad frame in VERIFY restarts the consecutive-good count
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    case (state_q)
      ST_SEARCH: begin
        if (frame_he) begin
          state_d    = ST_VERIFY;
          good_cnt_d = '0;
        end
      end
      ST_VERIFY: begin
        if (line_bad) begin
          state_d = ST_SEARCH;
        end else if (frame_he) begin
          if (frame_bad) begin
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_cnt_q + GW'(1);
            if ((good_cnt_q + GW'(1)) == GW'(LOCK_FRAMES)) state_d = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (line_bad || frame_bad) state_d = ST_SEARCH;
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  // Output decode for the current sample, using the post-transition lock state
  always_comb begin
    locked_d = (state_d == ST_LOCKED);
    h_win    = (h_cnt_d >= HW'(H_START)) && (h_cnt_d < HW'(H_START + H_VISIBLE));
    v_win    = (v_cnt_d >= VW'(V_START)) && (v_cnt_d < VW'(V_START + V_VISIBLE));
    vis_d    = h_win & v_win & locked_d;
    strobe_d = frame_he & locked_d;
    hpos_d   = '0;
    vpos_d   = '0;
    if (h_win && v_win) begin
      hpos_d = PW'(h_cnt_d - HW'(H_START));
      vpos_d = PW'(v_cnt_d - VW'(V_START));
    end
    red_d = vis_d ? i_red_video : '0;
    grn_d = vis_d ? i_grn_video : '0;
    blu_d = vis_d ? i_blu_video : '0;
  end

  // Timing tracker and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      v_arm_q   <= 1'b0;
      hpos_q    <= '0;
      vpos_q    <= '0;
      vis_q     <= 1'b0;
      strobe_q  <= 1'b0;
      locked_q  <= 1'b0;
      red_q     <= '0;
      grn_q     <= '0;
      blu_q     <= '0;
    end else begin
      hs_prev_q <= i_hsync;
      vs_prev_q <= i_vsync;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      v_arm_q   <= v_arm_d;
      hpos_q    <= hpos_d;
      vpos_q    <= vpos_d;
      vis_q     <= vis_d;
      strobe_q  <= strobe_d;
      locked_q  <= locked_d;
      red_q     <= red_d;
      grn_q     <= grn_d;
      blu_q     <= blu_d;
    end
  end

  assign o_hpos         = hpos_q;
  assign o_vpos         = vpos_q;
  assign o_visible      = vis_q;
  assign o_frame_strobe = strobe_q;
  assign o_locked       = locked_q;
  assign o_red_video    = red_q;
  assign o_grn_video    = grn_q;
  assign o_blu_video    = blu_q;

`ifdef VGA_DECODER_CRC_EN
  logic [CRW-1:0] crc_acc_q, crc_acc_d, frame_crc_q, frame_crc_d;

  // CRC-16-CCITT over one 9-bit pixel, MSB first
  function automatic logic [CRW-1:0] crc_pixel(input logic [CRW-1:0] c, input logic [8:0] d);
    logic [CRW-1:0] r;
    r = c;
    for (int i = 8; i >= 0; i--) begin
      if (r[CRW-1] ^ d[i]) r = {r[CRW-2:0], 1'b0} ^ 16'h1021;
      else                 r = {r[CRW-2:0], 1'b0};
    end
    return r;
  endfunction

  always_comb begin
    crc_acc_d   = crc_acc_q;
    frame_crc_d = frame_crc_q;
    if (vis_d) crc_acc_d = crc_pixel(crc_acc_q, {i_red_video, i_grn_video, i_blu_video});
    if (strobe_d) begin
      frame_crc_d = crc_acc_q;
      crc_acc_d   = 16'hFFFF;
    end
    if ((state_q == ST_LOCKED) && !locked_d) crc_acc_d = 16'hFFFF;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      crc_acc_q   <= 16'hFFFF;
      frame_crc_q <= 16'h0000;
    end else begin
      crc_acc_q   <= crc_acc_d;
      frame_crc_q <= frame_crc_d;
    end
  end

  assign o_frame_crc = frame_crc_q;
`else
  assign o_frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a scaled-down timing: random video against a sample-level reference model.
module tb_vga_sync_decoder;

  localparam int HV = 8, VV = 5, HT = 20, VT = 10, HS = 6, VS = 3, LF = 2, HSW = 3;

  logic        i_clk, i_rst_n, i_hsync, i_vsync;
  logic [2:0]  i_red_video, i_grn_video, i_blu_video;
  logic [9:0]  o_hpos, o_vpos;
  logic        o_visible, o_frame_strobe, o_locked;
  logic [2:0]  o_red_video, o_grn_video, o_blu_video;
  logic [15:0] o_frame_crc;

  vga_sync_decoder #(
    .H_VISIBLE(HV), .V_VISIBLE(VV), .H_TOTAL(HT), .V_TOTAL(VT),
    .H_START(HS), .V_START(VS), .LOCK_FRAMES(LF)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_hsync(i_hsync), .i_vsync(i_vsync),
    .i_red_video(i_red_video), .i_grn_video(i_grn_video), .i_blu_video(i_blu_video),
    .o_hpos(o_hpos), .o_vpos(o_vpos), .o_visible(o_visible),
    .o_frame_strobe(o_frame_strobe), .o_locked(o_locked),
    .o_red_video(o_red_video), .o_grn_video(o_grn_video), .o_blu_video(o_blu_video),
    .o_frame_crc(o_frame_crc)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: plain integers following the decoder's rules sample by sample
  bit          m_prev_h, m_prev_v, m_arm;
  int          m_hc, m_vc, m_good, m_fhe_cnt;
  int          m_mode;   // 0 search, 1 verify, 2 locked
  logic [15:0] m_acc, m_crc;
  int          e_hpos, e_vpos, e_r, e_g, e_b;
  bit          e_vis, e_strobe, e_locked;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [8:0] d);
    logic fb;
    for (int i = 8; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = c << 1;
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  task automatic model_reset();
    m_prev_h = 1; m_prev_v = 1; m_arm = 0;
    m_hc = 0; m_vc = 0; m_good = 0; m_fhe_cnt = 0; m_mode = 0;
    m_acc = 16'hFFFF; m_crc = 16'h0000;
    e_hpos = 0; e_vpos = 0; e_r = 0; e_g = 0; e_b = 0;
    e_vis = 0; e_strobe = 0; e_locked = 0;
  endtask

  task automatic model_step(input bit hs, input bit vs, input logic [2:0] r, input logic [2:0] g,
                            input logic [2:0] b);
    bit he, ve, fhe, line_ok, frame_ok, was_locked, in_win;
    he = m_prev_h && !hs;
    ve = m_prev_v && !vs;
    m_prev_h = hs;
    m_prev_v = vs;
    fhe = he && (m_arm || ve);
    line_ok = 1;
    frame_ok = 1;
    if (he) begin
      line_ok = (m_hc + 1 == HT);
      if (fhe) frame_ok = (m_vc + 1 == VT);
      m_hc = 0;
      if (fhe) begin m_vc = 0; m_arm = 0; end
      else m_vc = (m_vc + 1 > 1023) ? 1023 : m_vc + 1;
    end else begin
      m_hc = (m_hc + 1 > 2047) ? 2047 : m_hc + 1;
      if (ve) m_arm = 1;
    end
    if (m_hc == 2047) line_ok = 0;
    if (fhe) m_fhe_cnt++;
    was_locked = (m_mode == 2);
    if (m_mode == 0) begin
      if (fhe) begin m_mode = 1; m_good = 0; end
    end else if (m_mode == 1) begin
      if (!line_ok) m_mode = 0;
      else if (fhe) begin
        m_good = frame_ok ? m_good + 1 : 0;
        if (m_good == LF) m_mode = 2;
      end
    end else begin
      if (!line_ok || !frame_ok) m_mode = 0;
    end
    e_locked = (m_mode == 2);
    in_win   = (m_hc >= HS) && (m_hc < HS + HV) && (m_vc >= VS) && (m_vc < VS + VV);
    e_vis    = in_win && e_locked;
    e_hpos   = in_win ? m_hc - HS : 0;
    e_vpos   = in_win ? m_vc - VS : 0;
    e_r      = e_vis ? int'(r) : 0;
    e_g      = e_vis ? int'(g) : 0;
    e_b      = e_vis ? int'(b) : 0;
    e_strobe = fhe && e_locked;
`ifdef VGA_DECODER_CRC_EN
    if (e_vis) m_acc = crc_step(m_acc, {r, g, b});
    if (e_strobe) begin m_crc = m_acc; m_acc = 16'hFFFF; end
    if (was_locked && !e_locked) m_acc = 16'hFFFF;
`endif
  endtask

  task automatic compare_all();
    check("hpos",    32'(o_hpos),         32'(e_hpos));
    check("vpos",    32'(o_vpos),         32'(e_vpos));
    check("visible", 32'(o_visible),      32'(e_vis));
    check("strobe",  32'(o_frame_strobe), 32'(e_strobe));
    check("locked",  32'(o_locked),       32'(e_locked));
    check("red",     32'(o_red_video),    32'(e_r));
    check("grn",     32'(o_grn_video),    32'(e_g));
    check("blu",     32'(o_blu_video),    32'(e_b));
    check("crc",     32'(o_frame_crc),    32'(m_crc));
  endtask

  // Frame-level bookkeeping observed from the outputs
  int cyc = 0, rst_at = -1000, vs_left = 0;
  int last_strobe = -1, vis_cnt = 0, last_h = 0, last_v = 0;
  bit lock_seen = 0, first_pend = 0, skip_ve = 0;

  task automatic tick(input bit hs, input bit vs, input logic [2:0] r, input logic [2:0] g,
                      input logic [2:0] b);
    if (cyc == rst_at) begin
      i_rst_n = 1'b0;
      model_reset();
      lock_seen = 0; last_strobe = -1; first_pend = 0;
      #1;
      compare_all();
    end
    if (cyc == rst_at + 4) i_rst_n = 1'b1;
    i_hsync = hs; i_vsync = vs;
    i_red_video = r; i_grn_video = g; i_blu_video = b;
    if (i_rst_n) model_step(hs, vs, r, g, b);
    @(negedge i_clk);
    compare_all();
    if (o_locked && !lock_seen) begin
      lock_seen = 1;
      check("lock_at_frame_he", 32'(m_fhe_cnt), 32'(LF + 1));
    end
    if (o_visible) begin
      vis_cnt++;
      if (first_pend) begin
        check("first_hpos", 32'(o_hpos), 32'd0);
        check("first_vpos", 32'(o_vpos), 32'd0);
        first_pend = 0;
      end
      last_h = int'(o_hpos);
      last_v = int'(o_vpos);
    end
    if (o_frame_strobe) begin
      if (last_strobe >= 0) begin
        check("strobe_period", 32'(cyc - last_strobe), 32'(HT * VT));
        check("vis_per_frame", 32'(vis_cnt), 32'(HV * VV));
        check("last_hpos", 32'(last_h), 32'(HV - 1));
        check("last_vpos", 32'(last_v), 32'(VV - 1));
      end
      last_strobe = cyc;
      vis_cnt = 0;
      first_pend = 1;
    end
    if (!o_locked) begin last_strobe = -1; first_pend = 0; end
    cyc++;
  endtask

  function automatic bit vs_next();
    bit v;
    v = (vs_left > 0) ? 1'b0 : 1'b1;
    if (vs_left > 0) vs_left--;
    return v;
  endfunction

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      tick(1'b1, vs_next(), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
  endtask

  // mode 0 random colours, 1 all red, 2 position pattern (tweak flips one blue bit)
  task automatic send_frame(input int short_line, input bit early_next, input int mode, input bit tweak);
    int len;
    logic [2:0] r, g, b;
    for (int ln = 0; ln < VT; ln++) begin
      len = (ln == short_line) ? HT - 1 : HT;
      for (int c = 0; c < len; c++) begin
        if (ln == 0 && c == 0 && !skip_ve) vs_left = 2 * HT;
        if (ln == VT - 1 && early_next && c == len - 10) vs_left = 2 * HT;
        if (mode == 1) begin
          r = 3'd7; g = 3'd0; b = 3'd0;
        end else if (mode == 2) begin
          r = 3'(c); g = 3'(ln); b = 3'(c + ln);
          if (tweak && ln == VS + 2 && c == HS + 3) b = b ^ 3'd1;
        end else begin
          r = 3'($urandom_range(0, 7)); g = 3'($urandom_range(0, 7)); b = 3'($urandom_range(0, 7));
        end
        tick((c < HSW) ? 1'b0 : 1'b1, vs_next(), r, g, b);
      end
    end
    skip_ve = early_next;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_hsync = 1'b1; i_vsync = 1'b1;
    i_red_video = '0; i_grn_video = '0; i_blu_video = '0;
    model_reset();
    repeat (3) begin
      @(negedge i_clk);
      compare_all();
    end
    i_rst_n = 1'b1;

    idle($urandom_range(1, 15));
    repeat (4) send_frame(-1, 0, 0, 0);
    repeat (2) send_frame(-1, 0, 1, 0);

    send_frame($urandom_range(1, VT - 1), 0, 0, 0);
    repeat (3) send_frame(-1, 0, 0, 0);

    idle(2100);
    repeat (4) send_frame(-1, 0, 0, 0);

    send_frame(-1, 1, 0, 0);
    send_frame(-1, 1, 0, 0);
    repeat (2) send_frame(-1, 0, 0, 0);

    rst_at = cyc + HT * $urandom_range(3, 6) + $urandom_range(0, HT - 1);
    repeat (5) send_frame(-1, 0, 0, 0);

    repeat (3) send_frame(-1, 0, 2, 0);
    send_frame(-1, 0, 2, 1);
    repeat (2) send_frame(-1, 0, 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
